// File: rtl/adder_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared registered adder and returns tagged results.
// Define ADDER_ARB_FIXED_PRI_EN for fixed priority (lowest index wins); default is round-robin.
module adder_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2,
  localparam int NUM_REQ   = 2**ID_WIDTH
) (
  input  logic                          i_aclk,
  input  logic                          i_aresetn,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_b,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic [DATA_WIDTH-1:0]         o_add_a,
  output logic [DATA_WIDTH-1:0]         o_add_b,
  input  logic [DATA_WIDTH-1:0]         i_add_sum,
  output logic [DATA_WIDTH-1:0]         o_result,
  output logic [ID_WIDTH-1:0]           o_result_id,
  output logic                          o_result_valid,
  input  logic                          i_result_ready
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESULT
  } state_t;

  state_t              state_q, state_d;
  logic                grant_en;
  logic                grant_vld;
  logic [ID_WIDTH-1:0] grant_id;
  logic [ID_WIDTH-1:0] id_q;

`ifndef ADDER_ARB_FIXED_PRI_EN
  logic [ID_WIDTH-1:0] last_granted;
  logic [ID_WIDTH-1:0] rr_cand;
`endif

  // Grant only while reset is released so o_grant drops immediately on reset assertion.
  assign grant_en = i_aresetn &&
                    ((state_q == IDLE) || ((state_q == RESULT) && i_result_ready));

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
`ifdef ADDER_ARB_FIXED_PRI_EN
    if (grant_en) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!grant_vld && i_req[i]) begin
          grant_vld = 1'b1;
          grant_id  = ID_WIDTH'(i);
        end
      end
    end
`else
    rr_cand = '0;
    if (grant_en) begin
      // Offset NUM_REQ wraps to last_granted itself, so it is searched last.
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
        rr_cand = last_granted + ID_WIDTH'(i);
        if (!grant_vld && i_req[rr_cand]) begin
          grant_vld = 1'b1;
          grant_id  = rr_cand;
        end
      end
    end
`endif
  end

  always_comb begin
    o_grant = '0;
    if (grant_vld) o_grant[grant_id] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = ISSUE;
      ISSUE:   state_d = RESULT;
      RESULT:  if (i_result_ready) state_d = grant_vld ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q <= IDLE;
      o_add_a <= '0;
      o_add_b <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (grant_vld) begin
        o_add_a <= i_a[grant_id*DATA_WIDTH +: DATA_WIDTH];
        o_add_b <= i_b[grant_id*DATA_WIDTH +: DATA_WIDTH];
        id_q    <= grant_id;
      end
    end
  end

`ifndef ADDER_ARB_FIXED_PRI_EN
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      last_granted <= '1;
    end else if (grant_vld) begin
      last_granted <= grant_id;
    end
  end
`endif

  assign o_result       = i_add_sum;
  assign o_result_id    = id_q;
  assign o_result_valid = (state_q == RESULT);

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed plus random bench for adder_arbiter against a transaction-level reference model.
module tb_adder_arbiter;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] a_bus, b_bus;
  logic [N-1:0]    grant;
  logic [DW-1:0]   add_a, add_b, add_sum, result;
  logic [IW-1:0]   result_id;
  logic            result_valid, ready;

  int checks   = 0;
  int failures = 0;

  // Reference model state: one outstanding transaction and its age in cycles since grant.
  bit            m_busy;
  int            m_age;
  logic [DW-1:0] m_a, m_b;
  int            m_id;
  int            m_last;

  always #5 clk = ~clk;

  // Shared registered adder living outside the arbiter.
  always @(posedge clk) add_sum <= add_a + add_b;

  adder_arbiter #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .i_aclk         (clk),
    .i_aresetn      (rst_n),
    .i_req          (req),
    .i_a            (a_bus),
    .i_b            (b_bus),
    .o_grant        (grant),
    .o_add_a        (add_a),
    .o_add_b        (add_b),
    .i_add_sum      (add_sum),
    .o_result       (result),
    .o_result_id    (result_id),
    .o_result_valid (result_valid),
    .i_result_ready (ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int last);
    int k;
`ifdef ADDER_ARB_FIXED_PRI_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int o = 1; o <= N; o++) begin
      k = (last + o) % N;
      if (r[k]) return k;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_age  = 0;
    m_id   = 0;
    m_a    = '0;
    m_b    = '0;
    m_last = N - 1;
  endtask

  task automatic set_op(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
    a_bus[k*DW +: DW] = a;
    b_bus[k*DW +: DW] = b;
  endtask

  task automatic rand_ops();
    for (int k = 0; k < N; k++) set_op(k, $urandom, $urandom);
  endtask

  // One clock cycle: drive after the falling edge, check, advance model, cross the rising edge.
  task automatic step(input logic [N-1:0] r, input logic rdy);
    bit            may_grant;
    int            k;
    logic [N-1:0]  exp_g;
    logic [DW-1:0] exp_sum;
    req   = r;
    ready = rdy;
    #1;
    may_grant = !m_busy || (m_age >= 2 && rdy);
    k = may_grant ? pick(r, m_last) : -1;
    exp_g = '0;
    if (k >= 0) exp_g[k] = 1'b1;
    chk("grant", 64'(grant), 64'(exp_g));
    chk("valid", 64'(result_valid), 64'(m_busy && m_age >= 2));
    if (m_busy && m_age >= 2) begin
      exp_sum = m_a + m_b;
      chk("result", 64'(result), 64'(exp_sum));
      chk("result_id", 64'(result_id), 64'(m_id));
    end
    if (m_busy) begin
      chk("add_a", 64'(add_a), 64'(m_a));
      chk("add_b", 64'(add_b), 64'(m_b));
    end
    if (k >= 0) begin
      m_busy = 1;
      m_age  = 1;
      m_a    = a_bus[k*DW +: DW];
      m_b    = b_bus[k*DW +: DW];
      m_id   = k;
      m_last = k;
    end else if (m_busy && m_age >= 2 && rdy) begin
      m_busy = 0;
    end else if (m_busy && m_age < 2) begin
      m_age++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req   = '1;
    #1;
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_valid", 64'(result_valid), 64'(0));
    chk("rst_add_a", 64'(add_a), 64'(0));
    chk("rst_add_b", 64'(add_b), 64'(0));
    chk("rst_id", 64'(result_id), 64'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req   = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    ready = 1'b1;
    a_bus = '0;
    b_bus = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single requester 0: 5 + 7.
    set_op(0, 32'd5, 32'd7);
    step(4'b0001, 1'b1);
    step(4'b0000, 1'b1);
    #1;
    chk("d34_valid", 64'(result_valid), 64'(1));
    chk("d34_result", 64'(result), 64'd12);
    chk("d34_id", 64'(result_id), 64'd0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // All requesting continuously from reset: order 0,1,2,3,0 (fixed priority: always 0).
    do_reset();
    rand_ops();
    for (int i = 0; i < 10; i++) step(4'b1111, 1'b1);

    // Wrap-around sum.
    do_reset();
    set_op(0, 32'hFFFF_FFFF, 32'd2);
    step(4'b0001, 1'b1);
    step(4'b0000, 1'b1);
    #1;
    chk("d36_result", 64'(result), 64'd1);
    step(4'b0000, 1'b1);

    // Back-pressure: result held, no grants while ready is low.
    rand_ops();
    step(4'b0010, 1'b1);
    step(4'b1111, 1'b0);
    for (int i = 0; i < 5; i++) step(4'b1111, 1'b0);
    step(4'b1111, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // Reset in ISSUE, then requester 2 alone.
    rand_ops();
    step(4'b0001, 1'b1);
    do_reset();
    step(4'b0000, 1'b1);
    #1;
    chk("d38_valid_after", 64'(result_valid), 64'(0));
    set_op(2, 32'd1000, 32'd234);
    step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);
    #1;
    chk("d38_result", 64'(result), 64'd1234);
    chk("d38_id", 64'(result_id), 64'd2);
    step(4'b0000, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rand_ops();
      step(4'($urandom), ($urandom_range(0, 9) < 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand/result width, identical to the shared registered adder's width.
REQ-002 Parameter ID_WIDTH, default 2: requester index width; NUM_REQ = 2**ID_WIDTH requesters.
REQ-003 i_aclk  input  1  single clock; all state on rising edge.
REQ-004 i_aresetn  input  1  asynchronous, active-low reset.
REQ-005 i_req  input  NUM_REQ  per-requester request; operands valid while high.
REQ-006 i_a  input  NUM_REQ*DATA_WIDTH  packed operand A, requester k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 i_b  input  NUM_REQ*DATA_WIDTH  packed operand B, same packing.
REQ-008 o_grant  output  NUM_REQ  one-hot; bit k high = requester k's operands sampled this cycle.
REQ-009 o_add_a  output  DATA_WIDTH  registered operand A to shared adder.
REQ-010 o_add_b  output  DATA_WIDTH  registered operand B to shared adder.
REQ-011 i_add_sum  input  DATA_WIDTH  registered sum from shared adder (1-cycle latency).
REQ-012 o_result  output  DATA_WIDTH  result data; equals i_add_sum.
REQ-013 o_result_id  output  ID_WIDTH  index of requester owning o_result.
REQ-014 o_result_valid  output  1  result available.
REQ-015 i_result_ready  input  1  consumer accepts result when high with o_result_valid.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, RESULT.
REQ-017 o_grant SHALL be combinational, only in IDLE, or in RESULT when i_result_ready=1; otherwise all-zero.
REQ-018 At most one o_grant bit SHALL be high; none when i_req=0.
REQ-019 On grant to k: operands k SHALL load into o_add_a/o_add_b, k into ID register, next state ISSUE.
REQ-020 IDLE with no request SHALL remain IDLE.
REQ-021 ISSUE SHALL unconditionally advance to RESULT; no grant in ISSUE.
REQ-022 In RESULT, o_result_valid SHALL be 1 and o_result = i_add_sum; o_add_a/o_add_b SHALL hold, keeping the adder output stable.
REQ-023 RESULT with i_result_ready=0 SHALL stay RESULT with result, ID, operands unchanged.
REQ-024 RESULT with i_result_ready=1: grant present -> ISSUE (new operands loaded); no request -> IDLE.
REQ-025 Latency: grant in cycle T -> o_result_valid in T+2; sustained throughput one result per 2 cycles.
REQ-026 Arbitration round-robin: search starts at (last_granted+1) mod NUM_REQ, wraps; last_granted updates only on a grant.
REQ-027 Requester deasserting i_req before grant SHALL be dropped with no side effect; i_req held after grant is a new request.
REQ-028 No overflow flag; sum wraps modulo 2**DATA_WIDTH (adder behaviour, passed through).

Reset
REQ-029 Asserting i_aresetn low SHALL immediately force IDLE, o_grant=0, o_result_valid=0, o_add_a=0, o_add_b=0, o_result_id=0, last_granted=NUM_REQ-1.
REQ-030 Reset mid-transaction SHALL discard the in-flight result; no o_result_valid after release until a new grant plus 2 cycles.
REQ-031 First grant after reset with all requests high SHALL go to requester 0.

Configuration
REQ-032 Macro ADDER_ARB_FIXED_PRI_EN defined: fixed priority, lowest requesting index always wins, last_granted unused.
REQ-033 Macro undefined: round-robin per REQ-026.

Verification
REQ-034 Reset, req 0 only, a0=5, b0=7 -> grant[0] at T, valid at T+2, result=12, id=0.
REQ-035 All four requesting continuously, ready=1 -> grant order 0,1,2,3,0 at 2-cycle spacing; (fixed-pri build: always 0).
REQ-036 a=0xFFFFFFFF, b=2 -> result=1, valid=1.
REQ-037 Result pending, ready=0 for 5 cycles, other reqs high -> no grants, o_result/o_result_id stable; ready=1 -> next grant same cycle.
REQ-038 Reset asserted in ISSUE -> valid=0, grant=0 immediately; after release req 2 -> first grant to 2, result correct.
